// File: rtl/multi_channel_interval_timer.sv
// NUM_CH independent prescaled down-counting interval timers behind one 16-bit
// Avalon-MM slave; per-channel interrupts plus a global pending view.

module mcit_channel #(
    parameter int COUNT_WIDTH  = 32,
    parameter int RESET_PERIOD = 59999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [2:0]  reg_sel,
    input  logic [15:0] wdata,
    output logic [15:0] rd_word,
    output logic        irq_o
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [COUNT_WIDTH-1:0] cnt_d, cnt_q, period_d, period_q, snap_d, snap_q;
    logic [15:0]            pre_reg_d, pre_reg_q, pre_cnt_d, pre_cnt_q;
    logic [3:0]             ctrl_d, ctrl_q;
    logic [0:0]             state_d, state_q;
    logic                   to_d, to_q, reload_d, reload_q;
    logic                   run, tick, timeout;

    assign run     = (state_q == ST_RUN);
    assign tick    = run && (pre_cnt_q == '0);
    assign timeout = tick && (cnt_q == '0);
    assign irq_o   = to_q & ctrl_q[0];

    always_comb begin
        cnt_d     = cnt_q;
        period_d  = period_q;
        snap_d    = snap_q;
        pre_reg_d = pre_reg_q;
        ctrl_d    = ctrl_q;
        state_d   = state_q;
        to_d      = to_q;
        reload_d  = 1'b0;

        if (!run || tick) pre_cnt_d = pre_reg_q;
        else              pre_cnt_d = pre_cnt_q - 16'd1;

        if (tick) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                cnt_d = period_q;
                to_d  = 1'b1;
                if (!ctrl_q[1]) state_d = ST_IDLE;
            end
        end

        if (wr_en) begin
            case (reg_sel)
                // a timeout on the same edge keeps TO set
                3'd0: to_d = timeout;
                3'd1: begin
                    ctrl_d = wdata[3:0];
                    if (wdata[3])      state_d = ST_IDLE;
                    else if (wdata[2]) state_d = ST_RUN;
                end
                3'd2: begin
                    period_d = {period_q[COUNT_WIDTH-1:16], wdata};
                    reload_d = 1'b1;
                end
                3'd3: begin
                    period_d = COUNT_WIDTH'({wdata, period_q[15:0]});
                    reload_d = 1'b1;
                end
                3'd4, 3'd5: snap_d = cnt_q;
                3'd6: pre_reg_d = wdata;
                default: ;
            endcase
        end

        // reload lands one cycle after the period write and overrides a START
        if (reload_q) begin
            cnt_d     = period_q;
            pre_cnt_d = pre_reg_q;
            state_d   = ST_IDLE;
        end
    end

    always_comb begin
        rd_word = '0;
        case (reg_sel)
            3'd0: rd_word = {14'b0, run, to_q};
            3'd1: rd_word = {12'b0, ctrl_q};
            3'd2: rd_word = period_q[15:0];
            3'd3: rd_word = 16'(period_q[COUNT_WIDTH-1:16]);
            3'd4: rd_word = snap_q[15:0];
            3'd5: rd_word = 16'(snap_q[COUNT_WIDTH-1:16]);
            3'd6: rd_word = pre_reg_q;
            default: rd_word = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= COUNT_WIDTH'(RESET_PERIOD);
            period_q  <= COUNT_WIDTH'(RESET_PERIOD);
            snap_q    <= '0;
            pre_reg_q <= '0;
            pre_cnt_q <= '0;
            ctrl_q    <= '0;
            state_q   <= ST_IDLE;
            to_q      <= 1'b0;
            reload_q  <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            snap_q    <= snap_d;
            pre_reg_q <= pre_reg_d;
            pre_cnt_q <= pre_cnt_d;
            ctrl_q    <= ctrl_d;
            state_q   <= state_d;
            to_q      <= to_d;
            reload_q  <= reload_d;
        end
    end
endmodule

module multi_channel_interval_timer #(
    parameter int NUM_CH       = 4,
    parameter int COUNT_WIDTH  = 32,
    parameter int RESET_PERIOD = 59999,
    parameter int CH_AW        = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CH_AW+2:0]  address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [15:0]       writedata,
    output logic [15:0]       readdata,
    output logic              irq,
    output logic [NUM_CH-1:0] irq_vec
);
    localparam int CH_N = 1 << CH_AW;

    logic [CH_AW-1:0]       ch_sel;
    logic [2:0]             reg_sel;
    logic                   wr;
    logic [CH_N-1:0]        ch_ok;
    logic [CH_N-1:0][15:0]  rd_words;
    logic [15:0]            readdata_d, readdata_q;

    assign ch_sel  = address[CH_AW+2:3];
    assign reg_sel = address[2:0];
    assign wr      = chipselect & ~write_n;

    // unpopulated channel slots decode to zero and swallow writes
    for (genvar i = 0; i < CH_N; i++) begin : g_ch
        if (i < NUM_CH) begin : g_act
            assign ch_ok[i] = 1'b1;
            mcit_channel #(
                .COUNT_WIDTH  (COUNT_WIDTH),
                .RESET_PERIOD (RESET_PERIOD)
            ) u_ch (
                .clk     (clk),
                .reset   (reset),
                .wr_en   (wr && (ch_sel == CH_AW'(i))),
                .reg_sel (reg_sel),
                .wdata   (writedata),
                .rd_word (rd_words[i]),
                .irq_o   (irq_vec[i])
            );
        end else begin : g_pad
            assign ch_ok[i]    = 1'b0;
            assign rd_words[i] = '0;
        end
    end

    assign irq = |irq_vec;

    always_comb begin
        readdata_d = rd_words[ch_sel];
        if (reg_sel == 3'd7) readdata_d = ch_ok[ch_sel] ? 16'(irq_vec) : 16'h0;
    end

    always_ff @(posedge clk) begin
        if (reset) readdata_q <= '0;
        else       readdata_q <= readdata_d;
    end

    assign readdata = readdata_q;
endmodule
